memshare_ibram_remap_ctrl: RTL and testbench

- Controller for one IB-RAM share-group rank of SHARE_GROUP_SIZE VN LUTs.
- Arbitrates rank address/data ports between decoder read traffic and a LUT remap (reload) sequence.
- Remap: walks every {column, c2v} address, streams upstream LUT words into all elements, drives the active-low remap enable.
- Sits between the iteration scheduler/LUT loader and the rank wrapper.

---
 rtl/memshare_ibram_remap_ctrl.sv | 164 ++++++++++++++++
 tb/tb_memshare_ibram_remap_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memshare_ibram_remap_ctrl.sv
// IB-RAM share-group rank controller: arbitrates rank ports between decoder reads and a
// descending-column LUT remap walk. Optional stall watchdog: MEMSHARE_REMAP_TIMEOUT_EN.
module memshare_ibram_remap_ctrl #(
  parameter int QUAN_SIZE        = 4,
  parameter int SHARE_GROUP_SIZE = 4,
  parameter int COL_SEL_W        = 1,
  parameter int NUM_COLS         = 2,
  parameter int TIMEOUT_CYC      = 255
) (
  input  logic                                  sys_clk,
  input  logic                                  rst,
  input  logic                                  load_start_i,
  input  logic                                  load_abort_i,
  input  logic                                  ld_valid_i,
  output logic                                  ld_ready_o,
  input  logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0] ld_data_i,
  input  logic                                  dec_valid_i,
  output logic                                  dec_gnt_o,
  input  logic [COL_SEL_W*SHARE_GROUP_SIZE-1:0] dec_colSel_i,
  input  logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0] dec_c2v_i,
  output logic [COL_SEL_W*SHARE_GROUP_SIZE-1:0] colSel_vec_o,
  output logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0] c2v_vec_o,
  output logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0] remap_data_o,
  output logic                                  nRemap_en_o,
  output logic                                  busy_o,
  output logic                                  load_done_o,
  output logic                                  load_err_o,
  output logic [1:0]                            state_dbg_o
);

  localparam int MSG_W = QUAN_SIZE * SHARE_GROUP_SIZE;
  localparam int COL_W = COL_SEL_W * SHARE_GROUP_SIZE;
  localparam logic [COL_SEL_W-1:0] COL_FIRST = COL_SEL_W'(NUM_COLS - 1);
  localparam logic [QUAN_SIZE-1:0] MSG_LAST  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [COL_SEL_W-1:0] col_cnt, col_cnt_nxt;
  logic [QUAN_SIZE-1:0] msg_cnt, msg_cnt_nxt;
  logic                 err_nxt;
  logic                 wr_nxt;
  logic [COL_W-1:0]     col_sel_nxt;
  logic [MSG_W-1:0]     c2v_nxt;
  logic [MSG_W-1:0]     data_nxt;
  logic                 abort_req;

  // Handshakes: an LUT word transfers on a cycle where ld_valid_i and ld_ready_o are both
  // high (ld_ready_o is high for all of LOAD); a decoder read is taken on a cycle where
  // dec_valid_i and dec_gnt_o are both high, and an ungranted request must be held.

`ifdef MEMSHARE_REMAP_TIMEOUT_EN
  logic [7:0] stall_cnt;
  logic       timeout_hit;

  // Fires on the TIMEOUT_CYC-th consecutive stalled LOAD cycle.
  assign timeout_hit = (state == LOAD) && !ld_valid_i &&
                       (stall_cnt == 8'(TIMEOUT_CYC - 1));
  assign abort_req   = load_abort_i || timeout_hit;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state != LOAD) || ld_valid_i) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end
`else
  assign abort_req = load_abort_i;
`endif

  always_comb begin
    state_nxt   = state;
    col_cnt_nxt = col_cnt;
    msg_cnt_nxt = msg_cnt;
    err_nxt     = load_err_o;
    wr_nxt      = 1'b0;
    col_sel_nxt = colSel_vec_o;
    c2v_nxt     = c2v_vec_o;
    data_nxt    = remap_data_o;
    dec_gnt_o   = 1'b0;
    ld_ready_o  = 1'b0;
    busy_o      = 1'b0;
    load_done_o = 1'b0;
    unique case (state)
      IDLE: begin
        dec_gnt_o = dec_valid_i;
        if (dec_valid_i) begin
          col_sel_nxt = dec_colSel_i;
          c2v_nxt     = dec_c2v_i;
        end
        if (load_start_i) begin
          state_nxt   = LOAD;
          col_cnt_nxt = COL_FIRST;
          msg_cnt_nxt = '0;
          err_nxt     = 1'b0;
        end
      end
      LOAD: begin
        busy_o     = 1'b1;
        ld_ready_o = 1'b1;
        // Abort wins over a same-cycle handshake, including the final one.
        if (abort_req) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else if (ld_valid_i) begin
          wr_nxt      = 1'b1;
          col_sel_nxt = {SHARE_GROUP_SIZE{col_cnt}};
          c2v_nxt     = {SHARE_GROUP_SIZE{msg_cnt}};
          data_nxt    = ld_data_i;
          msg_cnt_nxt = msg_cnt + QUAN_SIZE'(1);
          if (msg_cnt == MSG_LAST) begin
            col_cnt_nxt = col_cnt - COL_SEL_W'(1);
            // Column 0 goes last so GP1 elements, which alias upper columns onto it,
            // finish holding column-0 content.
            if (col_cnt == '0) begin
              state_nxt   = DONE;
              col_cnt_nxt = COL_FIRST;
            end
          end
        end
      end
      DONE: begin
        busy_o      = 1'b1;
        load_done_o = 1'b1;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state        <= IDLE;
      col_cnt      <= COL_FIRST;
      msg_cnt      <= '0;
      load_err_o   <= 1'b0;
      nRemap_en_o  <= 1'b1;
      colSel_vec_o <= '0;
      c2v_vec_o    <= '0;
      remap_data_o <= '0;
    end else begin
      state        <= state_nxt;
      col_cnt      <= col_cnt_nxt;
      msg_cnt      <= msg_cnt_nxt;
      load_err_o   <= err_nxt;
      nRemap_en_o  <= ~wr_nxt;
      colSel_vec_o <= col_sel_nxt;
      c2v_vec_o    <= c2v_nxt;
      remap_data_o <= data_nxt;
    end
  end

  assign state_dbg_o = state;

endmodule

// File: tb/tb_memshare_ibram_remap_ctrl.sv
// Self-checking bench for memshare_ibram_remap_ctrl: write-index model plus directed
// scenarios (decoder read, full/gapped remap, abort, mid-load reset, optional timeout).
module tb_memshare_ibram_remap_ctrl;

  localparam int QS    = 4;
  localparam int SG    = 4;
  localparam int CW    = 1;
  localparam int NC    = 2;
  localparam int MW    = QS * SG;
  localparam int CVW   = CW * SG;
  localparam int PER_C = 1 << QS;
  localparam int TOTAL = NC * PER_C;

  logic           sys_clk = 1'b0;
  logic           rst = 1'b1;
  logic           load_start_i = 1'b0;
  logic           load_abort_i = 1'b0;
  logic           ld_valid_i = 1'b0;
  logic           ld_ready_o;
  logic [MW-1:0]  ld_data_i = '0;
  logic           dec_valid_i = 1'b0;
  logic           dec_gnt_o;
  logic [CVW-1:0] dec_colSel_i = '0;
  logic [MW-1:0]  dec_c2v_i = '0;
  logic [CVW-1:0] colSel_vec_o;
  logic [MW-1:0]  c2v_vec_o;
  logic [MW-1:0]  remap_data_o;
  logic           nRemap_en_o;
  logic           busy_o;
  logic           load_done_o;
  logic           load_err_o;
  logic [1:0]     state_dbg_o;

  memshare_ibram_remap_ctrl #(
    .QUAN_SIZE(QS), .SHARE_GROUP_SIZE(SG), .COL_SEL_W(CW), .NUM_COLS(NC), .TIMEOUT_CYC(255)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .load_start_i(load_start_i), .load_abort_i(load_abort_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_data_i(ld_data_i),
    .dec_valid_i(dec_valid_i), .dec_gnt_o(dec_gnt_o), .dec_colSel_i(dec_colSel_i),
    .dec_c2v_i(dec_c2v_i), .colSel_vec_o(colSel_vec_o), .c2v_vec_o(c2v_vec_o),
    .remap_data_o(remap_data_o), .nRemap_en_o(nRemap_en_o), .busy_o(busy_o),
    .load_done_o(load_done_o), .load_err_o(load_err_o), .state_dbg_o(state_dbg_o)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Write k of a remap lands on column NC-1-k/PER_C, message k%PER_C, replicated per element.
  function automatic logic [CVW-1:0] col_of(input int k);
    logic [CW-1:0] c;
    c = CW'(NC - 1 - k / PER_C);
    return {SG{c}};
  endfunction

  function automatic logic [MW-1:0] msg_of(input int k);
    logic [QS-1:0] m;
    m = QS'(k % PER_C);
    return {SG{m}};
  endfunction

  function automatic logic [MW-1:0] pat(input int i);
    logic [3:0] n;
    n = 4'(i);
    return 16'hA5C3 ^ {4{n}};
  endfunction

  typedef enum {M_IDLE, M_LOAD, M_DONE} mmode_t;
  mmode_t         m_mode = M_IDLE;
  int             m_k = 0;
  int             m_stall = 0;
  bit             m_wr = 1'b0;
  bit             m_err = 1'b0;
  bit             m_abort;
  logic [CVW-1:0] m_col = '0;
  logic [MW-1:0]  m_c2v = '0;
  logic [MW-1:0]  m_data = '0;
  logic [CVW+2*MW-1:0] exp_q[$];
  logic [CVW+2*MW-1:0] exp_w;

  always @(posedge sys_clk) begin
    if (rst) begin
      m_mode = M_IDLE; m_k = 0; m_stall = 0; m_wr = 1'b0; m_err = 1'b0;
      m_col = '0; m_c2v = '0; m_data = '0;
      exp_q.delete();
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_wr = 1'b0;
          if (dec_valid_i) begin
            m_col = dec_colSel_i;
            m_c2v = dec_c2v_i;
          end
          if (load_start_i) begin
            m_mode = M_LOAD; m_k = 0; m_err = 1'b0; m_stall = 0;
          end
        end
        M_LOAD: begin
          m_wr = 1'b0;
          m_abort = load_abort_i;
`ifdef MEMSHARE_REMAP_TIMEOUT_EN
          if (!ld_valid_i) begin
            m_stall++;
            if (m_stall >= 255) m_abort = 1'b1;
          end else begin
            m_stall = 0;
          end
`endif
          if (m_abort) begin
            m_mode = M_IDLE; m_err = 1'b1;
          end else if (ld_valid_i) begin
            m_wr = 1'b1;
            m_col = col_of(m_k);
            m_c2v = msg_of(m_k);
            m_data = ld_data_i;
            exp_q.push_back({m_col, m_c2v, m_data});
            m_k++;
            if (m_k == TOTAL) m_mode = M_DONE;
          end
        end
        default: begin
          m_wr = 1'b0;
          m_mode = M_IDLE;
        end
      endcase
    end
  end

  // ---------------- compare / scoreboard ----------------
  logic [CVW-1:0] obs_col[$];
  logic [MW-1:0]  obs_c2v[$];
  logic [MW-1:0]  obs_data[$];
  int             done_idx = -1;

  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("nRemap_en", nRemap_en_o, !m_wr);
      chk("dec_gnt", dec_gnt_o, (m_mode == M_IDLE) && dec_valid_i);
      chk("ld_ready", ld_ready_o, m_mode == M_LOAD);
      chk("busy", busy_o, m_mode != M_IDLE);
      chk("load_done", load_done_o, m_mode == M_DONE);
      chk("load_err", load_err_o, m_err);
      chk("colSel_vec", colSel_vec_o, m_col);
      chk("c2v_vec", c2v_vec_o, m_c2v);
      chk("remap_data", remap_data_o, m_data);
      if (nRemap_en_o === 1'b0) begin
        obs_col.push_back(colSel_vec_o);
        obs_c2v.push_back(c2v_vec_o);
        obs_data.push_back(remap_data_o);
        if (load_done_o === 1'b1) done_idx = obs_col.size();
        if (exp_q.size() == 0) begin
          chk("write_unexpected", 1, 0);
        end else begin
          exp_w = exp_q.pop_front();
          chk("write_word", {colSel_vec_o, c2v_vec_o, remap_data_o}, exp_w);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic clear_obs();
    obs_col.delete(); obs_c2v.delete(); obs_data.delete();
    done_idx = -1;
  endtask

  task automatic send_word(input int k, input int gap);
    ld_valid_i = 1'b1;
    ld_data_i = pat(k);
    step();
    ld_valid_i = 1'b0;
    repeat (gap) step();
  endtask

  task automatic start_load();
    load_start_i = 1'b1;
    step();
    load_start_i = 1'b0;
  endtask

  task automatic run_remap(input int gap);
    start_load();
    for (int k = 0; k < TOTAL; k++) send_word(k, gap);
    step();
    step();
  endtask

  // ---------------- directed sequence ----------------
  int bad;
  int tcyc;

  initial begin
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_nRemap", nRemap_en_o, 1'b1);
    chk("rst_err", load_err_o, 1'b0);
    chk("rst_vectors", {colSel_vec_o, c2v_vec_o, remap_data_o}, '0);
    chk("rst_busy_ready", {busy_o, ld_ready_o, load_done_o}, 3'b000);
    dec_valid_i = 1'b1;
    #1 chk("idle_gnt_hi", dec_gnt_o, 1'b1);
    dec_valid_i = 1'b0;
    #1 chk("idle_gnt_lo", dec_gnt_o, 1'b0);

    // decoder read
    step();
    dec_valid_i = 1'b1; dec_colSel_i = 4'b1010; dec_c2v_i = 16'h3C5A;
    step();
    dec_valid_i = 1'b0; dec_colSel_i = '0; dec_c2v_i = '0;
    chk("dec_colSel", colSel_vec_o, 4'b1010);
    chk("dec_c2v", c2v_vec_o, 16'h3C5A);
    chk("dec_nRemap", nRemap_en_o, 1'b1);
    step();
    chk("dec_hold", {colSel_vec_o, c2v_vec_o}, {4'b1010, 16'h3C5A});

    // full remap, valid every cycle
    clear_obs();
    run_remap(0);
    chk("full_writes", obs_col.size(), TOTAL);
    chk("full_first_col", obs_col[0], 4'b1111);
    chk("full_first_c2v", obs_c2v[0], 16'h0000);
    chk("full_first_data", obs_data[0], 16'hA5C3);
    chk("full_w16_col", obs_col[15], 4'b1111);
    chk("full_w17_col", obs_col[16], 4'b0000);
    chk("full_last_c2v", obs_c2v[31], 16'hFFFF);
    chk("full_last_data", obs_data[31], 16'h5A3C);
    chk("full_done_idx", done_idx, TOTAL);
    chk("full_idle", {busy_o, nRemap_en_o}, 2'b01);

    // gapped remap with a decoder request held throughout
    clear_obs();
    dec_valid_i = 1'b1; dec_colSel_i = 4'b0110; dec_c2v_i = 16'h1234;
    load_start_i = 1'b1;
    #1 chk("start_dec_gnt", dec_gnt_o, 1'b1);
    step();
    load_start_i = 1'b0;
    chk("load_dec_stall", dec_gnt_o, 1'b0);
    chk("start_dec_taken", colSel_vec_o, 4'b0110);
    for (int k = 0; k < TOTAL; k++) send_word(k, 2);
    step();
    step();
    chk("gap_writes", obs_col.size(), TOTAL);
    bad = 0;
    for (int k = 0; k < obs_col.size(); k++) begin
      if (obs_col[k] !== ((k < 16) ? 4'hF : 4'h0)) bad++;
      if (obs_c2v[k] !== {4{4'(k)}}) bad++;
    end
    chk("gap_order_errs", bad, 0);
    chk("gap_done_idx", done_idx, TOTAL);
    chk("gap_idle_gnt", dec_gnt_o, 1'b1);
    chk("gap_idle_dec", {colSel_vec_o, c2v_vec_o}, {4'b0110, 16'h1234});
    dec_valid_i = 1'b0;

    // abort after 10 handshakes; the handshake in the abort cycle is dropped
    clear_obs();
    start_load();
    for (int k = 0; k < 10; k++) send_word(k, 0);
    load_abort_i = 1'b1; ld_valid_i = 1'b1; ld_data_i = 16'hDEAD;
    step();
    load_abort_i = 1'b0; ld_valid_i = 1'b0;
    chk("abort_state", {load_err_o, ld_ready_o, busy_o, nRemap_en_o}, 4'b1001);
    step();
    step();
    chk("abort_writes", obs_col.size(), 10);
    clear_obs();
    start_load();
    chk("restart_err_clr", load_err_o, 1'b0);
    for (int k = 0; k < TOTAL; k++) send_word(k, 0);
    step();
    step();
    chk("restart_writes", obs_col.size(), TOTAL);
    chk("restart_first", {obs_col[0], obs_c2v[0]}, {4'b1111, 16'h0000});

    // reset in the middle of a load
    clear_obs();
    start_load();
    for (int k = 0; k < 3; k++) send_word(k, 0);
    rst = 1'b1; ld_valid_i = 1'b1;
    step();
    rst = 1'b0; ld_valid_i = 1'b0;
    chk("midrst_outputs", {nRemap_en_o, busy_o, ld_ready_o, load_err_o}, 4'b1000);
    chk("midrst_vectors", {colSel_vec_o, c2v_vec_o, remap_data_o}, '0);
    step();
    chk("midrst_writes", obs_col.size(), 3);

`ifdef MEMSHARE_REMAP_TIMEOUT_EN
    start_load();
    tcyc = 0;
    while (busy_o && tcyc < 300) begin
      step();
      tcyc++;
    end
    chk("timeout_cycles", tcyc, 255);
    chk("timeout_state", {load_err_o, busy_o, nRemap_en_o}, 3'b101);
    step();
`endif

    chk("exp_q_drained", exp_q.size(), 0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
